// File: rtl/sample_scheduler_pkg.sv
// Shared types and helpers for the sample scheduler: FSM states, point index
// type and the clock-to-sample divide ratio.
package sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [31:0] point_idx_t;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned smp_hz);
    return clk_hz / smp_hz;
  endfunction

endpackage

// File: rtl/sample_scheduler_if.sv
// Control/status bundle between a vector runner (master) and the scheduler (slave).
interface sample_scheduler_if #(
  parameter int unsigned ERR_W = 16
);
  import sched_pkg::*;

  logic             enable;
  logic             start;
  logic             abort;
  point_idx_t       total_points;
  logic             mismatch;
  logic             read_stb;
  logic             write_stb;
  point_idx_t       point_idx;
  logic [ERR_W-1:0] err_cnt;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output enable, start, abort, total_points, mismatch,
    input  read_stb, write_stb, point_idx, err_cnt, busy, done, aborted
  );

  modport slave (
    input  enable, start, abort, total_points, mismatch,
    output read_stb, write_stb, point_idx, err_cnt, busy, done, aborted
  );
endinterface

// File: rtl/sample_scheduler_strobe_divider.sv
// Divides the clock down to the test-point rate and decodes the read strobe
// (phase 0) and the write strobe (phase WR_OFFSET) of each point period.
module strobe_divider #(
  parameter int unsigned DIV       = 10,
  parameter int unsigned WR_OFFSET = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic enable,
  input  logic clear,
  output logic read_stb,
  output logic write_stb
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_WR   = CNT_W'(WR_OFFSET);

  logic [CNT_W-1:0] div_cnt;
  logic             active;

  assign active = run && enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (active) begin
      div_cnt <= (div_cnt == CNT_LAST) ? '0 : div_cnt + CNT_W'(1);
    end
  end

  assign read_stb  = active && (div_cnt == '0);
  assign write_stb = active && (div_cnt == CNT_WR);

endmodule

// File: rtl/sample_scheduler.sv
// Test-vector sequencer: issues read/write strobes once per sample period for
// total_points points and counts mismatching points.
module sample_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned DUT_CLK_FREQ = 100_000_000,
  parameter int unsigned SAMPLE_FREQ  = 10_000_000,
  parameter int unsigned WR_OFFSET    = calc_div(DUT_CLK_FREQ, SAMPLE_FREQ) / 2,
  parameter int unsigned ERR_W        = 16
) (
  input logic               clk,
  input logic               rst,
  sample_scheduler_if.slave bus
);

  localparam int unsigned DIV = calc_div(DUT_CLK_FREQ, SAMPLE_FREQ);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  if (DIV < 4) begin : g_div_chk
    $error("sample_scheduler: DUT_CLK_FREQ/SAMPLE_FREQ must be at least 4");
  end
  if ((WR_OFFSET < 1) || (WR_OFFSET > DIV - 2)) begin : g_wr_chk
    $error("sample_scheduler: WR_OFFSET must lie in 1..DIV-2");
  end

  state_t           state, state_nxt;
  logic             accept;
  logic             last_point;
  logic             read_stb, write_stb;
  point_idx_t       total_lat;
  point_idx_t       point_idx;
  logic [ERR_W-1:0] err_cnt;
  logic             aborted;

  strobe_divider #(
    .DIV       (DIV),
    .WR_OFFSET (WR_OFFSET)
  ) u_strobe_divider (
    .clk       (clk),
    .rst       (rst),
    .run       (state == ST_RUN),
    .enable    (bus.enable),
    .clear     (accept),
    .read_stb  (read_stb),
    .write_stb (write_stb)
  );

  assign last_point = (point_idx == total_lat - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Start is honoured identically from IDLE and DONE; a zero-length vector completes at once.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.total_points != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (bus.abort)                   state_nxt = ST_DONE;
        else if (write_stb && last_point) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) total_lat <= bus.total_points;
  end

  // Abort wins over a coincident write strobe: neither the index nor the error count moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      point_idx <= '0;
      err_cnt   <= '0;
      aborted   <= 1'b0;
    end else if (accept) begin
      point_idx <= '0;
      err_cnt   <= '0;
      aborted   <= 1'b0;
    end else if (state == ST_RUN) begin
      if (bus.abort) begin
        aborted <= 1'b1;
      end else if (write_stb) begin
        if (bus.mismatch && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + ERR_W'(1);
        if (!last_point) point_idx <= point_idx + 32'd1;
      end
    end
  end

  assign bus.read_stb  = read_stb;
  assign bus.write_stb = write_stb;
  assign bus.point_idx = point_idx;
  assign bus.err_cnt   = err_cnt;
  assign bus.busy      = (state == ST_RUN);
  assign bus.done      = (state == ST_DONE);
  assign bus.aborted   = aborted;

endmodule
